// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key debouncer: repeat FSM states,
// key index constants and the default auto-repeat enable mask.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD_WAIT,
      REPEATING
   } rpt_state_t;

   localparam int KEY_LEFT  = 0;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_ROT   = 2;
   localparam int KEY_DOWN  = 3;
   localparam int KEY_DROP  = 4;

   // Only the horizontal movement keys auto-repeat by default.
   localparam logic [4:0] DEFAULT_REPEAT_MASK = 5'b00011;

endpackage : key_pkg

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, tick-based stability filter, registered level,
// press/release pulses and an optional hold-to-repeat FSM.
module key_channel
   import key_pkg::*;
#(
   parameter int STABLE_TICKS = 5,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50,
   parameter bit REPEAT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic pressed,
   output logic released,
   output logic repeat_pulse,
   output logic action
);

   localparam int SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic [1:0]    sync_ff;
   logic [SW-1:0] stab_cnt;
   logic [RW-1:0] rpt_cnt;
   rpt_state_t    state;

   logic mismatch;
   logic flip;
   logic rise;
   logic fall;
   logic fire;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      fire     = 1'b0;
      mismatch = (sync_ff[1] != level);
      flip     = tick && mismatch && (stab_cnt == STAB_LAST);
      rise     = flip && !level;
      fall     = flip && level;
      // A release on the same tick as a due repeat suppresses the repeat.
      if (REPEAT_EN && tick && !fall) begin
         case (state)
            HOLD_WAIT: fire = (rpt_cnt == DELAY_LAST);
            REPEATING: fire = (rpt_cnt == RATE_LAST);
            default:   fire = 1'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff      <= '0;
         stab_cnt     <= '0;
         level        <= 1'b0;
         pressed      <= 1'b0;
         released     <= 1'b0;
         repeat_pulse <= 1'b0;
         action       <= 1'b0;
         rpt_cnt      <= '0;
         state        <= IDLE;
      end else begin
         sync_ff      <= {sync_ff[0], raw};
         pressed      <= rise;
         released     <= fall;
         repeat_pulse <= fire;
         action       <= rise | fire;

         if (!mismatch) begin
            stab_cnt <= '0;
         end else if (tick) begin
            stab_cnt <= flip ? '0 : stab_cnt + 1'b1;
         end

         if (flip) begin
            level <= ~level;
         end

         if (fall) begin
            state   <= IDLE;
            rpt_cnt <= '0;
         end else if (rise && REPEAT_EN) begin
            state   <= HOLD_WAIT;
            rpt_cnt <= '0;
         end else if (tick) begin
            case (state)
               HOLD_WAIT: begin
                  if (fire) begin
                     state   <= REPEATING;
                     rpt_cnt <= '0;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
               REPEATING: rpt_cnt <= fire ? '0 : rpt_cnt + 1'b1;
               default:   rpt_cnt <= '0;
            endcase
         end
      end
   end

endmodule : key_channel

// File: rtl/key_debounce_array.sv
// Multi-key debouncer: one shared tick prescaler feeding NUM_KEYS independent
// key_channel instances.
module key_debounce_array
   import key_pkg::*;
#(
   parameter int                  NUM_KEYS     = 5,
   parameter int                  TICK_DIV     = 100000,
   parameter int                  STABLE_TICKS = 5,
   parameter int                  REPEAT_DELAY = 250,
   parameter int                  REPEAT_RATE  = 50,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK  = DEFAULT_REPEAT_MASK
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] raw,
   output logic [NUM_KEYS-1:0] level,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] released,
   output logic [NUM_KEYS-1:0] repeat_pulse,
   output logic [NUM_KEYS-1:0] action
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tick;

   // With TICK_DIV=1 the counter sits at 0 and tick stays high.
   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
         .REPEAT_EN    (REPEAT_MASK[g])
      ) u_channel (
         .clk          (clk),
         .rst          (rst),
         .tick         (tick),
         .raw          (raw[g]),
         .level        (level[g]),
         .pressed      (pressed[g]),
         .released     (released[g]),
         .repeat_pulse (repeat_pulse[g]),
         .action       (action[g])
      );
   end

endmodule : key_debounce_array

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with a short tick (4 clk) so every
// expected pulse cycle is hand-derivable from the stimulus cycle.
module tb_key_debounce_array;
   import key_pkg::*;

   localparam int NK = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] raw = '0;
   logic [NK-1:0] level, pressed, released, repeat_pulse, action;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int press_n [NK], press_at [NK];
   int rel_n   [NK], rel_at   [NK];
   int rpt_n   [NK], rpt_first[NK], rpt_last[NK];
   int act_n   [NK], clash_n  [NK];

   key_debounce_array #(
      .NUM_KEYS     (NK),
      .TICK_DIV     (4),
      .STABLE_TICKS (3),
      .REPEAT_DELAY (5),
      .REPEAT_RATE  (2),
      .REPEAT_MASK  (5'b00011)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .raw          (raw),
      .level        (level),
      .pressed      (pressed),
      .released     (released),
      .repeat_pulse (repeat_pulse),
      .action       (action)
   );

   always #5 clk = ~clk;

   // Edges since the last reset edge; ticks land on edges where cyc%4==0.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic clear_mon();
      for (int i = 0; i < NK; i++) begin
         press_n[i] = 0;  press_at[i] = -1;
         rel_n[i]   = 0;  rel_at[i]   = -1;
         rpt_n[i]   = 0;  rpt_first[i] = -1; rpt_last[i] = -1;
         act_n[i]   = 0;  clash_n[i]  = 0;
      end
   endtask

   task automatic watch(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < NK; i++) begin
            if (pressed[i]) begin
               if (press_n[i] == 0) press_at[i] = cyc;
               press_n[i]++;
            end
            if (released[i]) begin
               if (rel_n[i] == 0) rel_at[i] = cyc;
               rel_n[i]++;
            end
            if (repeat_pulse[i]) begin
               if (rpt_n[i] == 0) rpt_first[i] = cyc;
               rpt_last[i] = cyc;
               rpt_n[i]++;
            end
            if (action[i]) act_n[i]++;
            if (released[i] && repeat_pulse[i]) clash_n[i]++;
         end
      end
   endtask

   task automatic align();
      for (int k = 0; k < 4 && (cyc % 4) != 0; k++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      raw = '0;
      repeat (3) @(negedge clk);
      checks++; if (level !== 5'b0) begin failures++; $display("FAIL reset_level got=%b exp=00000", level); end
      checks++; if (pressed !== 5'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=00000", pressed); end
      checks++; if (released !== 5'b0) begin failures++; $display("FAIL reset_released got=%b exp=00000", released); end
      checks++; if (repeat_pulse !== 5'b0) begin failures++; $display("FAIL reset_repeat got=%b exp=00000", repeat_pulse); end
      checks++; if (action !== 5'b0) begin failures++; $display("FAIL reset_action got=%b exp=00000", action); end
      rst = 1'b0;
   endtask

   task automatic test_clean_press();
      int n;
      align();
      n = cyc;
      raw[KEY_ROT] = 1'b1;
      clear_mon();
      watch(60);
      checks++; if (press_n[KEY_ROT] !== 1) begin failures++; $display("FAIL clean_press_count got=%0d exp=1", press_n[KEY_ROT]); end
      checks++; if (press_at[KEY_ROT] !== n + 12) begin failures++; $display("FAIL clean_press_cycle got=%0d exp=%0d", press_at[KEY_ROT], n + 12); end
      checks++; if (level[KEY_ROT] !== 1'b1) begin failures++; $display("FAIL clean_press_level got=%b exp=1", level[KEY_ROT]); end
      checks++; if (rpt_n[KEY_ROT] !== 0) begin failures++; $display("FAIL clean_masked_repeat got=%0d exp=0", rpt_n[KEY_ROT]); end
      checks++; if (act_n[KEY_ROT] !== 1) begin failures++; $display("FAIL clean_action_count got=%0d exp=1", act_n[KEY_ROT]); end
      align();
      n = cyc;
      raw[KEY_ROT] = 1'b0;
      clear_mon();
      watch(20);
      checks++; if (rel_n[KEY_ROT] !== 1) begin failures++; $display("FAIL clean_release_count got=%0d exp=1", rel_n[KEY_ROT]); end
      checks++; if (rel_at[KEY_ROT] !== n + 12) begin failures++; $display("FAIL clean_release_cycle got=%0d exp=%0d", rel_at[KEY_ROT], n + 12); end
      checks++; if (level[KEY_ROT] !== 1'b0) begin failures++; $display("FAIL clean_release_level got=%b exp=0", level[KEY_ROT]); end
   endtask

   // 6-cycle pulses span at most two ticks, never the three needed to flip.
   task automatic test_bounce();
      int n;
      align();
      n = cyc;
      clear_mon();
      for (int s = 0; s < 10; s++) begin
         raw[KEY_LEFT] = (s % 2 == 0);
         watch(6);
      end
      checks++; if (press_n[KEY_LEFT] !== 0) begin failures++; $display("FAIL bounce_no_press got=%0d exp=0", press_n[KEY_LEFT]); end
      checks++; if (level[KEY_LEFT] !== 1'b0) begin failures++; $display("FAIL bounce_level got=%b exp=0", level[KEY_LEFT]); end
      raw[KEY_LEFT] = 1'b1;
      watch(20);
      checks++; if (press_n[KEY_LEFT] !== 1) begin failures++; $display("FAIL bounce_hold_press got=%0d exp=1", press_n[KEY_LEFT]); end
      checks++; if (press_at[KEY_LEFT] !== n + 72) begin failures++; $display("FAIL bounce_press_cycle got=%0d exp=%0d", press_at[KEY_LEFT], n + 72); end
      checks++; if (rel_n[KEY_LEFT] !== 0) begin failures++; $display("FAIL bounce_no_release got=%0d exp=0", rel_n[KEY_LEFT]); end
      // Level falls at n+92, the tick where the first repeat would fire.
      raw[KEY_LEFT] = 1'b0;
      watch(20);
      checks++; if (rel_at[KEY_LEFT] !== n + 92) begin failures++; $display("FAIL bounce_release_cycle got=%0d exp=%0d", rel_at[KEY_LEFT], n + 92); end
      checks++; if (rpt_n[KEY_LEFT] !== 0) begin failures++; $display("FAIL holdwait_collision_repeat got=%0d exp=0", rpt_n[KEY_LEFT]); end
   endtask

   task automatic test_collision();
      int n;
      align();
      n = cyc;
      raw[KEY_LEFT] = 1'b1;
      clear_mon();
      watch(28);
      raw[KEY_LEFT] = 1'b0;
      watch(24);
      checks++; if (press_at[KEY_LEFT] !== n + 12) begin failures++; $display("FAIL coll_press_cycle got=%0d exp=%0d", press_at[KEY_LEFT], n + 12); end
      checks++; if (rpt_first[KEY_LEFT] !== n + 32) begin failures++; $display("FAIL coll_first_repeat got=%0d exp=%0d", rpt_first[KEY_LEFT], n + 32); end
      checks++; if (rpt_n[KEY_LEFT] !== 1) begin failures++; $display("FAIL coll_repeat_count got=%0d exp=1", rpt_n[KEY_LEFT]); end
      checks++; if (rel_at[KEY_LEFT] !== n + 40) begin failures++; $display("FAIL coll_release_cycle got=%0d exp=%0d", rel_at[KEY_LEFT], n + 40); end
      checks++; if (clash_n[KEY_LEFT] !== 0) begin failures++; $display("FAIL coll_clash got=%0d exp=0", clash_n[KEY_LEFT]); end
      checks++; if (act_n[KEY_LEFT] !== 2) begin failures++; $display("FAIL coll_action_count got=%0d exp=2", act_n[KEY_LEFT]); end
   endtask

   task automatic test_auto_repeat();
      int n;
      align();
      n = cyc;
      raw[KEY_RIGHT] = 1'b1;
      clear_mon();
      watch(120);
      checks++; if (press_at[KEY_RIGHT] !== n + 12) begin failures++; $display("FAIL rpt_press_cycle got=%0d exp=%0d", press_at[KEY_RIGHT], n + 12); end
      checks++; if (rpt_first[KEY_RIGHT] !== n + 32) begin failures++; $display("FAIL rpt_first_cycle got=%0d exp=%0d", rpt_first[KEY_RIGHT], n + 32); end
      checks++; if (rpt_last[KEY_RIGHT] !== n + 120) begin failures++; $display("FAIL rpt_last_cycle got=%0d exp=%0d", rpt_last[KEY_RIGHT], n + 120); end
      checks++; if (rpt_n[KEY_RIGHT] !== 12) begin failures++; $display("FAIL rpt_count got=%0d exp=12", rpt_n[KEY_RIGHT]); end
      checks++; if (act_n[KEY_RIGHT] !== 13) begin failures++; $display("FAIL rpt_action_count got=%0d exp=13", act_n[KEY_RIGHT]); end
      checks++; if (rpt_n[KEY_ROT] !== 0) begin failures++; $display("FAIL rpt_other_channel got=%0d exp=0", rpt_n[KEY_ROT]); end
   endtask

   // Runs straight after test_auto_repeat while channel 1 is still repeating.
   task automatic test_reset_mid();
      checks++; if (level[KEY_RIGHT] !== 1'b1) begin failures++; $display("FAIL mid_pre_level got=%b exp=1", level[KEY_RIGHT]); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({level, pressed, released, repeat_pulse, action} !== 25'b0) begin
         failures++; $display("FAIL mid_reset_outputs got=%b exp=0", {level, pressed, released, repeat_pulse, action});
      end
      clear_mon();
      watch(32);
      checks++; if (press_at[KEY_RIGHT] !== 12) begin failures++; $display("FAIL mid_repress_cycle got=%0d exp=12", press_at[KEY_RIGHT]); end
      checks++; if (rel_n[KEY_RIGHT] !== 0) begin failures++; $display("FAIL mid_no_release got=%0d exp=0", rel_n[KEY_RIGHT]); end
      checks++; if (rpt_first[KEY_RIGHT] !== 32) begin failures++; $display("FAIL mid_first_repeat got=%0d exp=32", rpt_first[KEY_RIGHT]); end
      clear_mon();
      raw[KEY_RIGHT] = 1'b0;
      watch(20);
      checks++; if (rel_at[KEY_RIGHT] !== 44) begin failures++; $display("FAIL mid_release_cycle got=%0d exp=44", rel_at[KEY_RIGHT]); end
      checks++; if (rpt_n[KEY_RIGHT] !== 1 || rpt_last[KEY_RIGHT] !== 40) begin
         failures++; $display("FAIL mid_repeat_after_release got=%0d@%0d exp=1@40", rpt_n[KEY_RIGHT], rpt_last[KEY_RIGHT]);
      end
   endtask

   task automatic test_parallel();
      int n;
      align();
      n = cyc;
      raw[KEY_DOWN] = 1'b1;
      raw[KEY_DROP] = 1'b1;
      clear_mon();
      watch(40);
      checks++; if (press_at[KEY_DOWN] !== n + 12) begin failures++; $display("FAIL par_down_cycle got=%0d exp=%0d", press_at[KEY_DOWN], n + 12); end
      checks++; if (press_at[KEY_DROP] !== n + 12) begin failures++; $display("FAIL par_drop_cycle got=%0d exp=%0d", press_at[KEY_DROP], n + 12); end
      checks++; if (press_n[KEY_LEFT] + press_n[KEY_RIGHT] + press_n[KEY_ROT] !== 0) begin
         failures++; $display("FAIL par_crosstalk got=%0d exp=0", press_n[KEY_LEFT] + press_n[KEY_RIGHT] + press_n[KEY_ROT]);
      end
      checks++; if (rpt_n[KEY_DOWN] + rpt_n[KEY_DROP] !== 0) begin
         failures++; $display("FAIL par_masked_repeat got=%0d exp=0", rpt_n[KEY_DOWN] + rpt_n[KEY_DROP]);
      end
      checks++; if (level !== 5'b11000) begin failures++; $display("FAIL par_level got=%b exp=11000", level); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_collision();
      test_auto_repeat();
      test_reset_mid();
      test_parallel();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_debounce_array
